load_store_unit: RTL



---
 rtl/load_store_unit.sv | 139 +++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// Byte-addressed load/store front end for the word-addressed Data_memory.
// Sub-word access (and its read-modify-write path) is built only with SUBWORD_ACCESS_EN.
module load_store_unit #(
  parameter int MEM_AW = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [MEM_AW-1:0] mem_address,
  output logic [31:0]       mem_data_in,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [31:0]       mem_data_out
);

  typedef enum logic [2:0] {IDLE, RD, RWAIT, WR, RESP} state_t;

  state_t            state_q, state_d;
  logic [MEM_AW+1:0] addr_q, addr_d;
  logic [1:0]        size_q, size_d;
  logic              signed_q, signed_d;
  logic              write_q, write_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;  // load result, or the old word during RMW
  logic              err_q, err_d;

  logic              req_bad;
  logic [31:0]       load_ext;
  logic [31:0]       wr_word;

`ifdef SUBWORD_ACCESS_EN
  logic [4:0]  lane_sh;
  logic [31:0] lane_data;
  logic [31:0] lane_mask;

  always_comb begin
    lane_sh   = (size_q == 2'b01) ? {addr_q[1], 4'b0000} : {addr_q[1:0], 3'b000};
    lane_data = mem_data_out >> lane_sh;
    case (size_q)
      2'b00:   load_ext = signed_q ? {{24{lane_data[7]}}, lane_data[7:0]}
                                   : {24'h0, lane_data[7:0]};
      2'b01:   load_ext = signed_q ? {{16{lane_data[15]}}, lane_data[15:0]}
                                   : {16'h0, lane_data[15:0]};
      default: load_ext = mem_data_out;
    endcase
    case (size_q)
      2'b00:   lane_mask = 32'h0000_00FF << lane_sh;
      2'b01:   lane_mask = 32'h0000_FFFF << lane_sh;
      default: lane_mask = 32'hFFFF_FFFF;
    endcase
    // Full-word stores never read, but the all-ones mask makes this yield wdata anyway.
    wr_word = (rdata_q & ~lane_mask) | ((wdata_q << lane_sh) & lane_mask);
  end

  assign req_bad = (|req_addr[31:MEM_AW+2]) || (req_size == 2'b11) ||
                   ((req_size == 2'b01) && req_addr[0]) ||
                   ((req_size == 2'b10) && (|req_addr[1:0]));
`else
  logic unused_subword;
  assign unused_subword = ^{addr_q[1:0], size_q, signed_q};
  assign load_ext = mem_data_out;
  assign wr_word  = wdata_q;
  assign req_bad  = (|req_addr[31:MEM_AW+2]) || (req_size != 2'b10) || (|req_addr[1:0]);
`endif

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    size_d   = size_q;
    signed_d = signed_q;
    write_d  = write_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    case (state_q)
      IDLE: if (req_valid) begin
        addr_d   = req_addr[MEM_AW+1:0];
        size_d   = req_size;
        signed_d = req_signed;
        write_d  = req_write;
        wdata_d  = req_wdata;
        rdata_d  = '0;
        err_d    = req_bad;
        if (req_bad)                               state_d = RESP;
        else if (req_write && req_size == 2'b10)   state_d = WR;
        else                                       state_d = RD;
      end
      RD:    state_d = RWAIT;
      RWAIT: begin
        rdata_d = write_q ? mem_data_out : load_ext;
        state_d = write_q ? WR : RESP;
      end
      WR:      state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      size_q   <= '0;
      signed_q <= 1'b0;
      write_q  <= 1'b0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      write_q  <= write_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign req_ready   = (state_q == IDLE);
  assign resp_valid  = (state_q == RESP);
  assign resp_err    = (state_q == RESP) && err_q;
  assign resp_rdata  = ((state_q == RESP) && !write_q && !err_q) ? rdata_q : 32'h0;
  assign mem_address = addr_q[MEM_AW+1:2];
  assign mem_read    = (state_q == RD);
  assign mem_write   = (state_q == WR);
  assign mem_data_in = (state_q == WR) ? wr_word : 32'h0;

endmodule
